texture_sampler: RTL and testbench
==================================

Name: texture_sampler

Overview:
Consumer stage directly downstream of the texture block memory. Accepts one sampling request (texture index, fixed-point u/v, filter mode) per handshake and drives the memory's texture-index input. It captures the 2048-bit texture block after the memory read latency, extracts texels and returns one 8-bit filtered texel (nearest or bilinear) over a valid/ready response channel. One request in flight; not pipelined.

Parameters:
TEX_DIM, 16, texels per row and rows per texture (fixed 16x16)
TEXEL_W, 8, bits per texel
UV_FRAC, 4, fractional bits of u/v (integer part = log2(TEX_DIM) = 4)
RAM_LAT, 1, cycles from o_texture_idx change to valid i_texture_data (1..4)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready at clk edge
i_req_tex_idx  in  8  texture index
i_req_u  in  8  u coordinate, 4.4 unsigned fixed point (column)
i_req_v  in  8  v coordinate, 4.4 unsigned fixed point (row)
i_req_bilinear  in  1  1 = bilinear, 0 = nearest
o_texture_idx  out  8  index to texture memory (full 8 bits; memory decodes [6:0])
i_texture_data  in  2048  texture block; row r = bits [128r+127:128r], texel c in row = bits [8c+7:8c]
o_rsp_valid  out  1  result valid
i_rsp_ready  in  1  result consumed when valid&ready at clk edge
o_rsp_texel  out  8  filtered texel

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, o_req_ready=0 during reset cycle then 1, o_rsp_valid=0, o_rsp_texel=0, o_texture_idx=0, latched u/v/mode=0.
- o_req_ready = (state==IDLE). Combinational from state only; never from i_req_valid.
- States: IDLE -> FETCH on accept; FETCH holds RAM_LAT cycles (down-counter) -> SAMPLE; SAMPLE -> BLEND; BLEND -> RESP; RESP -> IDLE on i_rsp_ready.
- Accept edge: register o_texture_idx<=i_req_tex_idx, u, v, mode. o_texture_idx held until next accept (not cleared on completion).
- SAMPLE edge: register t00=(vi,ui), t01=(vi,ui+1), t10=(vi+1,ui), t11=(vi+1,ui+1), fu=u[3:0], fv=v[3:0]; ui=u[7:4], vi=v[7:4]. +1 wraps mod 16 (15+1 -> 0) in both axes.
- BLEND edge: nearest: result=t00 (fraction truncated). Bilinear: top=t00*(16-fu)+t01*fu (12 bit); bot=t10*(16-fu)+t11*fu; res=(top*(16-fv)+bot*fv)>>8 (16-bit sum, truncation, no rounding); max 255, no saturation needed.
- Latency: o_rsp_valid rises RAM_LAT+2 edges after accept edge (RAM_LAT=1: 3 edges). Throughput: one result per RAM_LAT+4 cycles with i_rsp_ready=1.
- RESP: o_rsp_valid=1, o_rsp_texel stable until handshake; o_rsp_valid drops the cycle after handshake edge; o_req_ready rises the same cycle.
- i_texture_data sampled only at the SAMPLE edge; changes at other times ignored.
- i_req_* ignored when not ready; i_rsp_ready ignored outside RESP.
- rst in any state: abandon in-flight request, no response produced, outputs to reset values next cycle.

Decomposition:
- texture_pkg: TEX_DIM, TEXEL_W, ROW_W=128, BLOCK_W=2048, UV_FRAC, state encoding (IDLE, FETCH, SAMPLE, BLEND, RESP), texel-select helper function (row, col -> bit slice).
- One combinational sub-module texel_lerp (a, b, 4-bit frac -> a*(16-f)+b*f, width-parameterised), instantiated 3 times (top, bot, vertical).

Test Plan:
- Texture where texel(r,c)=16r+c, idx 0x05, nearest, u=0x35, v=0x27 -> o_texture_idx=0x05 after accept, o_rsp_texel=0x23, o_rsp_valid 3 edges after accept.
- Same texture, bilinear u=0x38, v=0x20 -> top=568, fv=0 -> o_rsp_texel=35 (0x23, 35.5 truncated).
- Wrap: bilinear u=0xF8, v=0xF0 -> t00=255, t01=240 -> o_rsp_texel=247; u=0xFF,v=0xFF nearest -> 255.
- Backpressure: hold i_rsp_ready=0 5 cycles in RESP -> o_rsp_valid=1, texel stable, o_req_ready=0 throughout; request held on i_req_valid not accepted until IDLE.
- rst asserted one cycle during FETCH -> next cycle o_rsp_valid=0, o_req_ready=1, o_texture_idx=0; no response ever appears for dropped request.
- Back-to-back: two requests with i_rsp_ready=1 -> second accepted exactly RAM_LAT+4 cycles after first; both results correct; sweep RAM_LAT=1 and 3.

Source files
------------

// File: rtl/texture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : texture_pkg
// Description : Shared constants, FSM encoding and texel-select helper for
//               the texture sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package texture_pkg;

    localparam int TEX_DIM = 16;
    localparam int TEXEL_W = 8;
    localparam int ROW_W   = TEX_DIM * TEXEL_W;
    localparam int BLOCK_W = ROW_W * TEX_DIM;
    localparam int UV_FRAC = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_BLEND  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // {row, col, 3'b0} is the bit offset of texel (row, col) in the block
    function automatic logic [TEXEL_W-1:0] texel_sel(
        input logic [BLOCK_W-1:0] blk,
        input logic [3:0]         row,
        input logic [3:0]         col
    );
        return blk[{row, col, 3'b000} +: TEXEL_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/texel_lerp.sv
`default_nettype none
// ============================================================================
// Module      : texel_lerp
// Description : Unnormalised linear blend a*(2^F - f) + b*f, combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module texel_lerp #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 4
) (
    input  logic [IN_W-1:0]        i_a,
    input  logic [IN_W-1:0]        i_b,
    input  logic [FRAC_W-1:0]      i_frac,
    output logic [IN_W+FRAC_W-1:0] o_mix
);

    localparam int OUT_W = IN_W + FRAC_W;

    logic [FRAC_W:0]  w_inv;
    logic [OUT_W-1:0] w_a;
    logic [OUT_W-1:0] w_b;
    logic [OUT_W-1:0] w_inv_ext;
    logic [OUT_W-1:0] w_frac_ext;

    always_comb begin
        w_inv      = (FRAC_W+1)'(2**FRAC_W) - {1'b0, i_frac};
        w_a        = {{FRAC_W{1'b0}}, i_a};
        w_b        = {{FRAC_W{1'b0}}, i_b};
        w_inv_ext  = {{(IN_W-1){1'b0}}, w_inv};
        w_frac_ext = {{IN_W{1'b0}}, i_frac};
        o_mix      = w_a * w_inv_ext + w_b * w_frac_ext;
    end

endmodule
`default_nettype wire

// File: rtl/texture_sampler.sv
`default_nettype none
// ============================================================================
// Module      : texture_sampler
// Description : Fetches a 16x16 texture block and returns one nearest or
//               bilinear filtered texel per request over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module texture_sampler
    import texture_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [7:0]          i_req_tex_idx,
    input  logic [7:0]          i_req_u,
    input  logic [7:0]          i_req_v,
    input  logic                i_req_bilinear,
    output logic [7:0]          o_texture_idx,
    input  logic [BLOCK_W-1:0]  i_texture_data,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [TEXEL_W-1:0]  o_rsp_texel
);

    localparam logic [1:0] c_lat_init = 2'(RAM_LAT - 1);

    state_t               state_q,   state_d;
    logic [1:0]           cnt_q,     cnt_d;
    logic [7:0]           tex_idx_q, tex_idx_d;
    logic [7:0]           u_q,       u_d;
    logic [7:0]           v_q,       v_d;
    logic                 bil_q,     bil_d;
    logic [TEXEL_W-1:0]   t00_q, t01_q, t10_q, t11_q;
    logic [TEXEL_W-1:0]   t00_d, t01_d, t10_d, t11_d;
    logic [UV_FRAC-1:0]   fu_q, fu_d, fv_q, fv_d;
    logic [TEXEL_W-1:0]   texel_q,   texel_d;

    logic [3:0]           w_ui, w_vi, w_ui1, w_vi1;
    logic [11:0]          w_top, w_bot;
    logic [15:0]          w_vert;

    texel_lerp #(.IN_W(TEXEL_W), .FRAC_W(UV_FRAC)) u_lerp_top (
        .i_a(t00_q), .i_b(t01_q), .i_frac(fu_q), .o_mix(w_top)
    );
    texel_lerp #(.IN_W(TEXEL_W), .FRAC_W(UV_FRAC)) u_lerp_bot (
        .i_a(t10_q), .i_b(t11_q), .i_frac(fu_q), .o_mix(w_bot)
    );
    texel_lerp #(.IN_W(12), .FRAC_W(UV_FRAC)) u_lerp_vert (
        .i_a(w_top), .i_b(w_bot), .i_frac(fv_q), .o_mix(w_vert)
    );

    always_comb begin
        w_ui  = u_q[7:4];
        w_vi  = v_q[7:4];
        // 4-bit add wraps the neighbour back to column/row 0
        w_ui1 = w_ui + 4'd1;
        w_vi1 = w_vi + 4'd1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        tex_idx_d = tex_idx_q;
        u_d       = u_q;
        v_d       = v_q;
        bil_d     = bil_q;
        t00_d     = t00_q;
        t01_d     = t01_q;
        t10_d     = t10_q;
        t11_d     = t11_q;
        fu_d      = fu_q;
        fv_d      = fv_q;
        texel_d   = texel_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d   = ST_FETCH;
                    cnt_d     = c_lat_init;
                    tex_idx_d = i_req_tex_idx;
                    u_d       = i_req_u;
                    v_d       = i_req_v;
                    bil_d     = i_req_bilinear;
                end
            end
            ST_FETCH: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_SAMPLE: begin
                t00_d   = texel_sel(i_texture_data, w_vi,  w_ui);
                t01_d   = texel_sel(i_texture_data, w_vi,  w_ui1);
                t10_d   = texel_sel(i_texture_data, w_vi1, w_ui);
                t11_d   = texel_sel(i_texture_data, w_vi1, w_ui1);
                fu_d    = u_q[3:0];
                fv_d    = v_q[3:0];
                state_d = ST_BLEND;
            end
            ST_BLEND: begin
                texel_d = bil_q ? w_vert[15:8] : t00_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            tex_idx_q <= 8'd0;
            u_q       <= 8'd0;
            v_q       <= 8'd0;
            bil_q     <= 1'b0;
            t00_q     <= '0;
            t01_q     <= '0;
            t10_q     <= '0;
            t11_q     <= '0;
            fu_q      <= '0;
            fv_q      <= '0;
            texel_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tex_idx_q <= tex_idx_d;
            u_q       <= u_d;
            v_q       <= v_d;
            bil_q     <= bil_d;
            t00_q     <= t00_d;
            t01_q     <= t01_d;
            t10_q     <= t10_d;
            t11_q     <= t11_d;
            fu_q      <= fu_d;
            fv_q      <= fv_d;
            texel_q   <= texel_d;
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_rsp_valid   = (state_q == ST_RESP);
    assign o_texture_idx = tex_idx_q;
    assign o_rsp_texel   = texel_q;

endmodule
`default_nettype wire

// File: tb/tb_texture_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_texture_sampler
// Description : Self-checking bench; two samplers (RAM_LAT 1 and 3) against
//               a behavioural texture memory and filter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_texture_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       req_valid [2];
    logic       req_ready [2];
    logic [7:0] req_idx   [2];
    logic [7:0] req_u     [2];
    logic [7:0] req_v     [2];
    logic       req_bil   [2];
    logic [7:0] tex_idx   [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_texel [2];

    logic [7:0] tex_mem [128][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0]    pipe [LAT];
        logic [2047:0] blk;

        // Memory model: block for the index presented LAT edges earlier
        always @(posedge clk) begin
            pipe[0] <= tex_idx[g];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        always_comb begin
            blk = '0;
            for (int k = 0; k < 256; k++) blk[k*8 +: 8] = tex_mem[int'(pipe[LAT-1][6:0])][k];
        end

        texture_sampler #(.RAM_LAT(LAT)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_tex_idx  (req_idx[g]),
            .i_req_u        (req_u[g]),
            .i_req_v        (req_v[g]),
            .i_req_bilinear (req_bil[g]),
            .o_texture_idx  (tex_idx[g]),
            .i_texture_data (blk),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_texel    (rsp_texel[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Weighted sum of the four neighbours with exact integer weights
    function automatic logic [7:0] ref_texel(input logic [7:0] idx, input logic [7:0] u,
                                             input logic [7:0] v, input bit bil);
        int t = int'(idx[6:0]);
        int ui = int'(u) / 16, vi = int'(v) / 16;
        int fu = int'(u) % 16, fv = int'(v) % 16;
        int ui1 = (ui + 1) % 16, vi1 = (vi + 1) % 16;
        int t00 = int'(tex_mem[t][vi*16 + ui]);
        int t01 = int'(tex_mem[t][vi*16 + ui1]);
        int t10 = int'(tex_mem[t][vi1*16 + ui]);
        int t11 = int'(tex_mem[t][vi1*16 + ui1]);
        int acc;
        if (!bil) return 8'(t00);
        acc = t00*(16-fu)*(16-fv) + t01*fu*(16-fv) + t10*(16-fu)*fv + t11*fu*fv;
        return 8'(acc / 256);
    endfunction

    task automatic issue(input int d, input logic [7:0] idx, input logic [7:0] u,
                         input logic [7:0] v, input bit bil, output int acc_cyc, output bit ok);
        ok = 1'b0;
        req_idx[d] = idx; req_u[d] = u; req_v[d] = v; req_bil[d] = bil;
        req_valid[d] = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (req_ready[d]) ok = 1'b1;
            @(posedge clk); #1;
        end
        acc_cyc = cyc;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, output logic [7:0] t, output int rsp_cyc, output bit ok);
        ok = 1'b0; t = 8'h00; rsp_cyc = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rsp_valid[d]) begin
                ok = 1'b1; t = rsp_texel[d]; rsp_cyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    // One full transaction; response consumed after `stall` cycles
    task automatic run_one(input int d, input logic [7:0] idx, input logic [7:0] u,
                           input logic [7:0] v, input bit bil, input int stall,
                           output logic [7:0] t, output int lat, output bit ok);
        int  a, r;
        bit  ok_a, ok_r;
        rsp_ready[d] = (stall == 0);
        issue(d, idx, u, v, bil, a, ok_a);
        wait_rsp(d, t, r, ok_r);
        repeat (stall) begin @(posedge clk); #1; end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        ok = ok_a && ok_r;
        lat = r - a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rsp_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); end
            n_checks++;
            if (rsp_texel[d] !== 8'h00) begin n_fail++; $display("FAIL reset_texel[%0d]: got %h want 00", d, rsp_texel[d]); end
            n_checks++;
            if (tex_idx[d] !== 8'h00) begin n_fail++; $display("FAIL reset_tex_idx[%0d]: got %h want 00", d, tex_idx[d]); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b want 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_nearest();
        int a, r; bit ok; logic [7:0] t;
        rsp_ready[0] = 1'b1;
        issue(0, 8'h05, 8'h35, 8'h27, 1'b0, a, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nearest_accept: got timeout want accept"); end
        n_checks++;
        if (tex_idx[0] !== 8'h05) begin n_fail++; $display("FAIL nearest_tex_idx: got %h want 05", tex_idx[0]); end
        wait_rsp(0, t, r, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nearest_rsp: got timeout want valid"); end
        n_checks++;
        if (r - a != 3) begin n_fail++; $display("FAIL nearest_latency: got %0d want 3", r - a); end
        n_checks++;
        if (t !== 8'h23) begin n_fail++; $display("FAIL nearest_texel: got %h want 23", t); end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL nearest_complete: got valid=%b ready=%b want 0/1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_bilinear_and_wrap();
        logic [7:0] idx [3] = '{8'h05, 8'h05, 8'h05};
        logic [7:0] u   [3] = '{8'h38, 8'hF8, 8'hFF};
        logic [7:0] v   [3] = '{8'h20, 8'hF0, 8'hFF};
        bit         b   [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] exp [3] = '{8'd35, 8'd247, 8'd255};
        logic [7:0] t; int lat; bit ok;
        for (int i = 0; i < 3; i++) begin
            run_one(0, idx[i], u[i], v[i], b[i], 0, t, lat, ok);
            n_checks++;
            if (!ok || t !== exp[i]) begin
                n_fail++; $display("FAIL bilin_wrap[%0d]: got %0d ok=%b want %0d", i, t, ok, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int a, r; bit ok; logic [7:0] t0, t;
        logic [7:0] u2 = 8'($urandom), v2 = 8'($urandom);
        rsp_ready[0] = 1'b0;
        issue(0, 8'h05, 8'h12, 8'h34, 1'b1, a, ok);
        wait_rsp(0, t0, r, ok);
        n_checks++;
        if (!ok || t0 !== ref_texel(8'h05, 8'h12, 8'h34, 1'b1)) begin
            n_fail++; $display("FAIL bp_first: got %h ok=%b want %h", t0, ok, ref_texel(8'h05, 8'h12, 8'h34, 1'b1));
        end
        req_idx[0] = 8'h07; req_u[0] = u2; req_v[0] = v2; req_bil[0] = 1'b1;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_texel[0] !== t0 || req_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b texel=%h ready=%b want 1/%h/0",
                                   i, rsp_valid[0], rsp_texel[0], req_ready[0], t0);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || tex_idx[0] !== 8'h05) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b idx=%h want 0/1/05",
                               rsp_valid[0], req_ready[0], tex_idx[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (tex_idx[0] !== 8'h07) begin n_fail++; $display("FAIL bp_second_accept: got %h want 07", tex_idx[0]); end
        wait_rsp(0, t, r, ok);
        n_checks++;
        if (!ok || t !== ref_texel(8'h07, u2, v2, 1'b1)) begin
            n_fail++; $display("FAIL bp_second: got %h ok=%b want %h", t, ok, ref_texel(8'h07, u2, v2, 1'b1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_fetch(input int d);
        int a; bit ok; bit seen = 1'b0;
        rsp_ready[d] = 1'b1;
        issue(d, 8'h09, 8'h44, 8'h55, 1'b1, a, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || tex_idx[d] !== 8'h00) begin
            n_fail++; $display("FAIL rst_fetch[%0d]: got valid=%b ready=%b idx=%h want 0/1/00",
                               d, rsp_valid[d], req_ready[d], tex_idx[d]);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[d]) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rst_fetch_no_rsp[%0d]: got response want none", d); end
    endtask

    task automatic test_back_to_back(input int d);
        logic [7:0] ia, ua, va, ib, ub, vb; bit ba, bb;
        logic [7:0] got [2];
        int acc [2];
        int n_acc = 0, n_rsp = 0;
        bit acc_now;
        ia = 8'($urandom); ua = 8'($urandom); va = 8'($urandom); ba = 1'($urandom);
        ib = 8'($urandom); ub = 8'($urandom); vb = 8'($urandom); bb = 1'($urandom);
        rsp_ready[d] = 1'b1;
        req_idx[d] = ia; req_u[d] = ua; req_v[d] = va; req_bil[d] = ba;
        req_valid[d] = 1'b1;
        for (int i = 0; i < 100 && n_rsp < 2; i++) begin
            acc_now = req_valid[d] && req_ready[d];
            if (rsp_valid[d]) begin got[n_rsp] = rsp_texel[d]; n_rsp++; end
            @(posedge clk); #1;
            if (acc_now) begin
                acc[n_acc] = cyc; n_acc++;
                if (n_acc == 1) begin
                    req_idx[d] = ib; req_u[d] = ub; req_v[d] = vb; req_bil[d] = bb;
                end else begin
                    req_valid[d] = 1'b0;
                end
            end
        end
        req_valid[d] = 1'b0;
        n_checks++;
        if (n_rsp != 2 || n_acc != 2) begin
            n_fail++; $display("FAIL b2b_count[%0d]: got acc=%0d rsp=%0d want 2/2", d, n_acc, n_rsp);
        end else begin
            n_checks++;
            if (acc[1] - acc[0] != lat_of(d) + 4) begin
                n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", d, acc[1] - acc[0], lat_of(d) + 4);
            end
            n_checks++;
            if (got[0] !== ref_texel(ia, ua, va, ba) || got[1] !== ref_texel(ib, ub, vb, bb)) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %h,%h want %h,%h", d, got[0], got[1],
                                   ref_texel(ia, ua, va, ba), ref_texel(ib, ub, vb, bb));
            end
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [7:0] idx, u, v, t; bit b, ok; int lat;
        for (int i = 0; i < n; i++) begin
            idx = 8'($urandom); u = 8'($urandom); v = 8'($urandom); b = 1'($urandom);
            run_one(d, idx, u, v, b, $urandom_range(0, 3), t, lat, ok);
            n_checks++;
            if (!ok || lat != lat_of(d) + 2 || t !== ref_texel(idx, u, v, b)) begin
                n_fail++; $display("FAIL random[%0d.%0d]: got texel=%h lat=%0d ok=%b want texel=%h lat=%0d",
                                   d, i, t, lat, ok, ref_texel(idx, u, v, b), lat_of(d) + 2);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_idx[d] = 8'h00; req_u[d] = 8'h00;
            req_v[d] = 8'h00; req_bil[d] = 1'b0; rsp_ready[d] = 1'b1;
        end
        for (int t = 0; t < 128; t++)
            for (int k = 0; k < 256; k++)
                tex_mem[t][k] = (t == 5) ? 8'(k) : 8'($urandom);

        test_reset();
        test_nearest();
        test_bilinear_and_wrap();
        test_backpressure();
        test_reset_in_fetch(0);
        test_reset_in_fetch(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_random(0, 25);
        test_random(1, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
